demux_1to4_reg: RTL and testbench

- 1:4 demultiplexer that routes one data input to one of four outputs, chosen by a 2-bit select (s1, s0).
- Contains three internal routing implementations: behavioural (case on select), dataflow (continuous assigns), and gate-level (primitive NOT/AND gates).
- Outputs are registered. A registered cross-check flags any disagreement between the three implementations.
- Used as a registered steering stage in front of four downstream consumers.

---
 rtl/demux_1to4_reg.sv | 133 +++++++++++++
 tb/tb_demux_1to4_reg.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/demux_1to4_reg.sv
// demux_1to4_reg: registered 1:4 demultiplexer with three redundant routing
// implementations (behavioural, dataflow, gate-level) and a registered
// cross-check that flags any disagreement between them.
module demux_1to4_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic             s0,
    input  logic             s1,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic             out_valid,
    output logic             mismatch,
    output logic             err_sticky
);

    // ------------------------------------------------------------------
    // Behavioural path. This result is the one that gets registered.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_beh1, w_beh2, w_beh3, w_beh4;

    // Select decode via case; every output gets a default, so no latches.
    always_comb begin
        w_beh1 = '0;
        w_beh2 = '0;
        w_beh3 = '0;
        w_beh4 = '0;
        case ({s1, s0})
            2'b00:   w_beh1 = a;
            2'b01:   w_beh2 = a;
            2'b10:   w_beh3 = a;
            2'b11:   w_beh4 = a;
            default: begin
                w_beh1 = '0;
                w_beh2 = '0;
                w_beh3 = '0;
                w_beh4 = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Dataflow path: the routing equations, with the select term
    // replicated across the data width.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_df1, w_df2, w_df3, w_df4;

    assign w_df1 = a & {WIDTH{~s1 & ~s0}};
    assign w_df2 = a & {WIDTH{~s1 &  s0}};
    assign w_df3 = a & {WIDTH{ s1 & ~s0}};
    assign w_df4 = a & {WIDTH{ s1 &  s0}};

    // ------------------------------------------------------------------
    // Gate-level path: shared inverted selects, one 3-input AND per bit
    // per output.
    // ------------------------------------------------------------------
    logic             w_s0_n, w_s1_n;
    logic [WIDTH-1:0] w_gl1, w_gl2, w_gl3, w_gl4;

    not g_inv_s0 (w_s0_n, s0);
    not g_inv_s1 (w_s1_n, s1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        and g_and1 (w_gl1[i], a[i], w_s1_n, w_s0_n);
        and g_and2 (w_gl2[i], a[i], w_s1_n, s0);
        and g_and3 (w_gl3[i], a[i], s1,     w_s0_n);
        and g_and4 (w_gl4[i], a[i], s1,     s0);
    end

    // ------------------------------------------------------------------
    // Cross-check: any bit of any output differing between the behavioural
    // result and either of the other two. Only meaningful on valid samples.
    // ------------------------------------------------------------------
    logic w_diff_df, w_diff_gl, w_mis_next;

    assign w_diff_df  = (w_beh1 != w_df1) | (w_beh2 != w_df2) |
                        (w_beh3 != w_df3) | (w_beh4 != w_df4);
    assign w_diff_gl  = (w_beh1 != w_gl1) | (w_beh2 != w_gl2) |
                        (w_beh3 != w_gl3) | (w_beh4 != w_gl4);
    assign w_mis_next = in_valid & (w_diff_df | w_diff_gl);

    // ------------------------------------------------------------------
    // Register stage
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_out1, r_out2, r_out3, r_out4;
    logic             r_out_valid, r_mismatch, r_err_sticky;

    // Data outputs load on valid samples and hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out1 <= '0;
            r_out2 <= '0;
            r_out3 <= '0;
            r_out4 <= '0;
        end else if (in_valid) begin
            r_out1 <= w_beh1;
            r_out2 <= w_beh2;
            r_out3 <= w_beh3;
            r_out4 <= w_beh4;
        end
    end

    // out_valid is a one-cycle-delayed copy of in_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_out_valid <= 1'b0;
        else     r_out_valid <= in_valid;
    end

    // mismatch reflects the last sample; err_sticky latches any mismatch until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mismatch   <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            r_mismatch   <= w_mis_next;
            r_err_sticky <= r_err_sticky | w_mis_next;
        end
    end

    assign out1       = r_out1;
    assign out2       = r_out2;
    assign out3       = r_out3;
    assign out4       = r_out4;
    assign out_valid  = r_out_valid;
    assign mismatch   = r_mismatch;
    assign err_sticky = r_err_sticky;

endmodule

// File: tb/tb_demux_1to4_reg.sv
// tb_demux_1to4_reg: drives a WIDTH=1 and a WIDTH=4 instance from shared
// select/valid/reset and compares both against an array-based reference.
module tb_demux_1to4_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       s0 = 1'b0, s1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [3:0] a4 = '0;

    logic [0:0] n1_o1, n1_o2, n1_o3, n1_o4;
    logic [3:0] n4_o1, n4_o2, n4_o3, n4_o4;
    logic       n1_v, n1_m, n1_e, n4_v, n4_m, n4_e;

    int total  = 0;
    int passed = 0;

    // Reference state: one slot per output, indexed by the select value.
    logic [3:0] m1 [4];
    logic [3:0] m4 [4];
    logic       mv;

    always #5 clk = ~clk;

    demux_1to4_reg #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a1), .s0(s0), .s1(s1),
        .out1(n1_o1), .out2(n1_o2), .out3(n1_o3), .out4(n1_o4),
        .out_valid(n1_v), .mismatch(n1_m), .err_sticky(n1_e)
    );

    demux_1to4_reg #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a4), .s0(s0), .s1(s1),
        .out1(n4_o1), .out2(n4_o2), .out3(n4_o3), .out4(n4_o4),
        .out_valid(n4_v), .mismatch(n4_m), .err_sticky(n4_e)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m1[k] = '0;
            m4[k] = '0;
        end
        mv = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".w1.out1"}, {3'b0, n1_o1}, m1[0]);
        check({tag, ".w1.out2"}, {3'b0, n1_o2}, m1[1]);
        check({tag, ".w1.out3"}, {3'b0, n1_o3}, m1[2]);
        check({tag, ".w1.out4"}, {3'b0, n1_o4}, m1[3]);
        check({tag, ".w4.out1"}, n4_o1, m4[0]);
        check({tag, ".w4.out2"}, n4_o2, m4[1]);
        check({tag, ".w4.out3"}, n4_o3, m4[2]);
        check({tag, ".w4.out4"}, n4_o4, m4[3]);
        check({tag, ".w1.vld"},  {3'b0, n1_v}, {3'b0, mv});
        check({tag, ".w4.vld"},  {3'b0, n4_v}, {3'b0, mv});
        check({tag, ".w1.mis"},  {3'b0, n1_m}, 4'h0);
        check({tag, ".w4.mis"},  {3'b0, n4_m}, 4'h0);
        check({tag, ".w1.err"},  {3'b0, n1_e}, 4'h0);
        check({tag, ".w4.err"},  {3'b0, n4_e}, 4'h0);
    endtask

    // Advance one edge: a valid sample overwrites all four slots (the selected
    // one with the data, the rest with 0); an invalid sample keeps the slots.
    task automatic tick(input string tag);
        int sel;
        sel = 2 * int'(s1) + int'(s0);
        if (in_valid) begin
            for (int k = 0; k < 4; k++) begin
                m1[k] = (k == sel) ? {3'b0, a1} : 4'h0;
                m4[k] = (k == sel) ? a4 : 4'h0;
            end
        end
        mv = in_valid;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [2:0] cnt;
        model_reset();

        // Reset with inputs pushing toward out4 / valid.
        #2;
        a1 = 1'b1; a4 = 4'hF; s1 = 1'b1; s0 = 1'b1; in_valid = 1'b1;
        rst = 1'b1;
        #1 check_all("rst_during");
        @(posedge clk); #1 check_all("rst_edge");
        @(negedge clk); rst = 1'b0;
        #1 check_all("rst_release");

        // Exhaustive sweep of {s1,s0,a}; wide instance gets random data.
        in_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            cnt = 3'(c);
            s1 = cnt[2]; s0 = cnt[1]; a1 = cnt[0];
            a4 = 4'($urandom_range(0, 15));
            tick($sformatf("sweep%0d", c));
            // Reset mid-stream, asserted between edges.
            if (c == 4) begin
                #2 rst = 1'b1;
                model_reset();
                #1 check_all("midrst_async");
                @(negedge clk); rst = 1'b0;
                #1 check_all("midrst_release");
            end
        end

        // Hold: load out3, then invalid cycles with changed inputs.
        s1 = 1'b1; s0 = 1'b0; a1 = 1'b1; a4 = 4'h9; in_valid = 1'b1;
        tick("hold_load");
        in_valid = 1'b0; a1 = 1'b0; a4 = 4'h0; s1 = 1'b0; s0 = 1'b1;
        for (int k = 0; k < 3; k++) tick($sformatf("hold%0d", k));
        check("hold.out3_const", {3'b0, n1_o3}, 4'h1);

        // Directed wide-data cases.
        in_valid = 1'b1; s1 = 1'b0; s0 = 1'b1; a4 = 4'hA; a1 = 1'b1;
        tick("w4_A");
        check("w4_A.out2_const", n4_o2, 4'hA);
        s1 = 1'b1; s0 = 1'b1; a4 = 4'h5; a1 = 1'b0;
        tick("w4_5");
        check("w4_5.out4_const", n4_o4, 4'h5);

        // Random traffic.
        for (int k = 0; k < 200; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            s0 = 1'($urandom_range(0, 1));
            s1 = 1'($urandom_range(0, 1));
            a1 = 1'($urandom_range(0, 1));
            a4 = 4'($urandom_range(0, 15));
            tick($sformatf("rnd%0d", k));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
